// File: rtl/mux16_sched_pkg.sv
// Shared types, sizes and the reference round-robin scan for the 16-way bit-mux scheduler.
package mux16_sched_pkg;

  localparam int unsigned N     = 16;
  localparam int unsigned SEL_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Index of the first set request scanning ptr, ptr+1, ... wrapping mod N.
  // Returns 0 when no request is set.
  function automatic logic [SEL_W-1:0] rr_first(input logic [N-1:0] req,
                                                input logic [SEL_W-1:0] ptr);
    logic [SEL_W-1:0] res;
    logic [SEL_W-1:0] j;
    logic             found;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = SEL_W'(int'(ptr) + k);
      if (!found && req[j]) begin
        res   = j;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux16_rr_sched_if.sv
// Requester/downstream bundle of the scheduler.
//   req, din, out_ready : driven by requesters / downstream (master side)
//   gnt, sel, out_bit, out_valid, busy : driven by the scheduler (slave side)
interface mux16_rr_sched_if;
  import mux16_sched_pkg::*;

  logic [N-1:0]     req;
  logic [N-1:0]     din;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] sel;
  logic             out_bit;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    output req, din, out_ready,
    input  gnt, sel, out_bit, out_valid, busy
  );

  modport slave (
    input  req, din, out_ready,
    output gnt, sel, out_bit, out_valid, busy
  );

endinterface

// File: rtl/mux16.sv
// Existing 16:1 bit mux built as a tree of 2:1 stages.
//   d : 16 data inputs, s : select, y : d[s]
module mux16 (
  input  logic [15:0] d,
  input  logic [3:0]  s,
  output logic        y
);

  logic [7:0] l1;
  logic [3:0] l2;
  logic [1:0] l3;

  for (genvar i = 0; i < 8; i++) begin : g_l1
    assign l1[i] = s[0] ? d[2*i+1] : d[2*i];
  end

  for (genvar i = 0; i < 4; i++) begin : g_l2
    assign l2[i] = s[1] ? l1[2*i+1] : l1[2*i];
  end

  for (genvar i = 0; i < 2; i++) begin : g_l3
    assign l3[i] = s[2] ? l2[2*i+1] : l2[2*i];
  end

  assign y = s[3] ? l3[1] : l3[0];

endmodule

// File: rtl/rr_pick16.sv
// Combinational round-robin picker: rotate req so ptr sits at bit 0,
// priority-encode the lowest set bit, then add ptr back (mod 16).
//   req : request vector, ptr : highest-priority index
//   idx : chosen index (valid when any), any : some request set
module rr_pick16
  import mux16_sched_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [N-1:0]     rot;
  logic [SEL_W-1:0] off;

  // rot[i] is the request ptr+i positions away
  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req[SEL_W'(int'(ptr) + i)];
    end
  end

  // Downward scan so the lowest set bit wins
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  assign idx = ptr + off;
  assign any = |req;

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler owning the select of the 16:1 bit mux.
//   clk, rst : clock and async active-high reset
//   bus      : req/din/out_ready in; gnt/sel (registered), out_bit (through mux),
//              out_valid (req[sel] while owned), busy (grant owned) out
module mux16_rr_sched
  import mux16_sched_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic clk,
  input  logic rst,
  mux16_rr_sched_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_XFER = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             own;
  logic             valid;
  logic             xfer;
  logic             mux_y;

  rr_pick16 u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  mux16 u_mux (
    .d (bus.din),
    .s (sel_q),
    .y (mux_y)
  );

  assign own   = (state_q == OWN);
  assign valid = own & bus.req[sel_q];
  assign xfer  = valid & bus.out_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: arbitrate in IDLE, count transfers / release in OWN.
  // sel is left alone on release so the mux keeps its last path.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = OWN;
          sel_d   = pick_idx;
          gnt_d   = N'(1) << pick_idx;
          cnt_d   = '0;
        end
      end
      OWN: begin
        if (!bus.req[sel_q] || (xfer && (cnt_q == LAST_XFER))) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + 1'b1;
          cnt_d   = '0;
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.out_bit   = mux_y;
  assign bus.out_valid = valid;
  assign bus.busy      = own;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_gnt_own:     assert property (@(posedge clk) disable iff (rst) ((gnt_q != '0) == own));
  a_valid_busy:  assert property (@(posedge clk) disable iff (rst) (valid |-> own));
  a_pick_ref:    assert property (@(posedge clk) disable iff (rst)
                   ((!own && pick_any) |-> (pick_idx == rr_first(bus.req, ptr_q))));

endmodule
